branch_resolve: RTL

Execute-stage branch resolution unit. Consumes the `takeBranch`/`branchType` pair produced by the decode-side branch logic, evaluates the condition on the register operands, and computes the target. For taken branches it drives a PC redirect to fetch with a valid/ready handshake, then holds a pipeline flush for a fixed number of cycles. It also keeps resolved and taken branch counters for performance monitoring.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_resolve_if.sv | 35 +++
 rtl/branch_compare.sv | 35 +++
 rtl/branch_resolve.sv | 87 ++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch types for decode-side branch logic and the execute-stage resolver.
// Latency: n/a (types only).
// Backpressure: n/a.
package branch_pkg;

    // funct3 encodings of the conditional branches; 010/011 are unused codes
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } br_state_t;

endpackage

// File: rtl/branch_resolve_if.sv
// Execute-stage <-> branch resolver bundle: instruction in, redirect/flush/perf out.
// Latency: n/a (wires only).
// Backpressure: in_ready gates instructions; redirect_ready gates the redirect.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            takeBranch;
    logic [2:0]      branchType;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic [31:0]     branch_count;
    logic [31:0]     taken_count;

    // master: execute stage / fetch side driving the resolver
    modport master (
        output in_valid, takeBranch, branchType, pc, imm, rs1_data, rs2_data,
               redirect_ready,
        input  in_ready, redirect_valid, redirect_pc, flush, branch_count, taken_count
    );

    // slave: the resolver itself
    modport slave (
        input  in_valid, takeBranch, branchType, pc, imm, rs1_data, rs2_data,
               redirect_ready,
        output in_ready, redirect_valid, redirect_pc, flush, branch_count, taken_count
    );
endinterface

// File: rtl/branch_compare.sv
// Branch condition evaluator: equality, signed and unsigned compares.
// Latency: combinational.
// Backpressure: none.
// Ports: branchType (funct3), rs1_data/rs2_data operands -> cond_true.
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      branchType,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            cond_true
);
    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (rs1_data == rs2_data);
    assign w_lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign w_ltu = (rs1_data < rs2_data);

    always_comb begin
        cond_true = 1'b0;
        case (branchType)
            BEQ:     cond_true = w_eq;
            BNE:     cond_true = !w_eq;
            BLT:     cond_true = w_lt;
            BGE:     cond_true = !w_lt;
            BLTU:    cond_true = w_ltu;
            BGEU:    cond_true = !w_ltu;
            default: cond_true = 1'b0;  // unused codes never take
        endcase
    end
endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: condition, target, PC redirect, timed flush, perf counters.
// Latency: accept in N -> redirect_valid/counters from N+1; flush for FLUSH_CYCLES after handshake.
// Backpressure: in_ready low while redirecting/flushing; redirect held until redirect_ready.
// Ports: clk, rst (async, active-high), bus (branch_resolve_if.slave).
module branch_resolve
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    branch_resolve_if.slave    bus
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    br_state_t       r_state;
    br_state_t       w_next_state;
    logic [CW-1:0]   r_flush_cnt;
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_branch_count;
    logic [31:0]     r_taken_count;

    logic            w_cond;
    logic            w_accept;
    logic [XLEN-1:0] w_target;

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .branchType (bus.branchType),
        .rs1_data   (bus.rs1_data),
        .rs2_data   (bus.rs2_data),
        .cond_true  (w_cond)
    );

    // wraps mod 2^XLEN; bit 0 cleared to keep the target halfword aligned
    assign w_target = bus.pc + bus.imm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid && bus.takeBranch) begin
                    w_accept = 1'b1;
                    if (w_cond) w_next_state = REDIRECT;
                end
            end
            REDIRECT: if (bus.redirect_ready) w_next_state = FLUSH;
            FLUSH:    if (r_flush_cnt == '0) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt    <= '0;
            r_redirect_pc  <= '0;
            r_branch_count <= '0;
            r_taken_count  <= '0;
        end else begin
            if (w_accept) begin
                r_branch_count <= r_branch_count + 32'd1;
                if (w_cond) begin
                    r_taken_count <= r_taken_count + 32'd1;
                    r_redirect_pc <= {w_target[XLEN-1:1], 1'b0};
                end
            end
            if (r_state == REDIRECT && bus.redirect_ready)
                r_flush_cnt <= CW'(FLUSH_CYCLES - 1);
            else if (r_state == FLUSH && r_flush_cnt != '0)
                r_flush_cnt <= r_flush_cnt - CW'(1);
        end
    end

    // outputs decode straight from state so reset drops them without a clock edge
    assign bus.in_ready       = (r_state == IDLE) && !rst;
    assign bus.redirect_valid = (r_state == REDIRECT);
    assign bus.flush          = (r_state == FLUSH);
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.branch_count   = r_branch_count;
    assign bus.taken_count    = r_taken_count;
endmodule
